// File: rtl/stream_packer.sv
// -----------------------------------------------------------------------------
// stream_packer
//   Packs LANES consecutive DATA_W-bit bytes from a valid/ready byte stream
//   into one LANES*DATA_W-bit word with a byte-enable mask. A single output
//   word register decouples the packer from the downstream stage, so the
//   upstream is only stalled when a word closes while the previous word is
//   still waiting to be taken. Flush_i closes a partial word early.
//
// Ports
//   CLK      rising-edge clock
//   RESET    synchronous, active-high reset
//   Valid_i  upstream byte valid
//   Ready_o  packer can accept a byte this cycle (no path from Valid_i)
//   Data_i   upstream byte
//   Flush_i  close the current word after this cycle's accepted byte (if any)
//   Valid_o  output word valid (registered)
//   Ready_i  downstream accepts the word
//   Data_o   packed word, lane 0 = first byte in the LSBs (registered)
//   Keep_o   byte enables, bit k set when lane k holds real data (registered)
// -----------------------------------------------------------------------------
module stream_packer #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     Valid_i,
    output logic                     Ready_o,
    input  logic [DATA_W-1:0]        Data_i,
    input  logic                     Flush_i,
    output logic                     Valid_o,
    input  logic                     Ready_i,
    output logic [DATA_W*LANES-1:0]  Data_o,
    output logic [LANES-1:0]         Keep_o
);

    localparam int                IDX_W    = $clog2(LANES);
    localparam int                WORD_W   = DATA_W * LANES;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LANES - 1);

    logic [IDX_W-1:0]   r_idx;
    logic [WORD_W-1:0]  r_acc;
    logic [LANES-1:0]   r_acc_keep;
    logic               r_valid_o;
    logic [WORD_W-1:0]  r_data_o;
    logic [LANES-1:0]   r_keep_o;

    logic               w_last_lane;
    logic               w_can_load;
    logic               w_ready;
    logic               w_xfer_in;
    logic               w_close;
    logic [WORD_W-1:0]  w_acc_merged;
    logic [LANES-1:0]   w_keep_merged;

    // Handshake qualifiers and the accumulator view including this cycle's byte
    always_comb begin
        w_last_lane   = (r_idx == LAST_IDX);
        // The output register can take a new word if it is empty or being drained.
        w_can_load    = !r_valid_o || Ready_i;
        // A close is only possible on the last lane or with a flush; Valid_i is
        // deliberately not used so Ready_o never depends on it.
        w_ready       = !(w_last_lane || Flush_i) || w_can_load;
        w_xfer_in     = Valid_i && w_ready;
        // Flush-only closes (no byte) still need room in the output register.
        w_close       = w_can_load &&
                        ((w_xfer_in && w_last_lane) ||
                         (Flush_i && ((r_acc_keep != {LANES{1'b0}}) || w_xfer_in)));
        w_acc_merged  = r_acc;
        w_keep_merged = r_acc_keep;
        for (int k = 0; k < LANES; k++) begin
            w_acc_merged[k*DATA_W +: DATA_W] =
                (w_xfer_in && (r_idx == IDX_W'(k))) ? Data_i : r_acc[k*DATA_W +: DATA_W];
            w_keep_merged[k] =
                (w_xfer_in && (r_idx == IDX_W'(k))) ? 1'b1 : r_acc_keep[k];
        end
    end

    // Accumulator, lane index and output word register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_idx      <= {IDX_W{1'b0}};
            r_acc      <= {WORD_W{1'b0}};
            r_acc_keep <= {LANES{1'b0}};
            r_valid_o  <= 1'b0;
            r_data_o   <= {WORD_W{1'b0}};
            r_keep_o   <= {LANES{1'b0}};
        end else if (w_close) begin
            // Unwritten lanes are already zero in the accumulator.
            r_data_o   <= w_acc_merged;
            r_keep_o   <= w_keep_merged;
            r_valid_o  <= 1'b1;
            r_acc      <= {WORD_W{1'b0}};
            r_acc_keep <= {LANES{1'b0}};
            r_idx      <= {IDX_W{1'b0}};
        end else begin
            if (r_valid_o && Ready_i) begin
                r_valid_o <= 1'b0;
            end else begin
                r_valid_o <= r_valid_o;
            end
            if (w_xfer_in) begin
                r_acc      <= w_acc_merged;
                r_acc_keep <= w_keep_merged;
                r_idx      <= r_idx + IDX_W'(1);
            end else begin
                r_acc      <= r_acc;
                r_acc_keep <= r_acc_keep;
                r_idx      <= r_idx;
            end
        end
    end

    assign Ready_o = w_ready;
    assign Valid_o = r_valid_o;
    assign Data_o  = r_data_o;
    assign Keep_o  = r_keep_o;

endmodule

// File: tb/tb_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_stream_packer
//   Directed bench for stream_packer (DATA_W=8, LANES=4). A small packing
//   model builds each expected word from accepted bytes and pushes it to a
//   scoreboard queue; words are popped and compared on output transfers.
// -----------------------------------------------------------------------------
module tb_stream_packer;

    logic        CLK;
    logic        RESET;
    logic        Valid_i;
    logic        Ready_o;
    logic [7:0]  Data_i;
    logic        Flush_i;
    logic        Valid_o;
    logic        Ready_i;
    logic [31:0] Data_o;
    logic [3:0]  Keep_o;

    int checks   = 0;
    int failures = 0;

    logic [35:0] q[$];
    logic [31:0] m_acc;
    logic [3:0]  m_keep;
    int          m_idx;
    logic        last_acc;

    stream_packer #(.DATA_W(8), .LANES(4)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .Valid_i (Valid_i),
        .Ready_o (Ready_o),
        .Data_i  (Data_i),
        .Flush_i (Flush_i),
        .Valid_o (Valid_o),
        .Ready_i (Ready_i),
        .Data_o  (Data_o),
        .Keep_o  (Keep_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score the output transfer, update the model, advance past the edge.
    task automatic tick();
        logic        acc;
        logic [35:0] e;
        #1;
        last_acc = 1'b0;
        if (RESET) begin
            q.delete();
            m_acc  = 32'h0;
            m_keep = 4'h0;
            m_idx  = 0;
        end else begin
            if (Valid_o && Ready_i) begin
                chk("sb_avail", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("word_data", 64'(Data_o), 64'(e[31:0]));
                    chk("word_keep", 64'(Keep_o), 64'(e[35:32]));
                end
            end
            acc      = Valid_i && Ready_o;
            last_acc = acc;
            if (acc) begin
                m_acc[m_idx*8 +: 8] = Data_i;
                m_keep[m_idx]       = 1'b1;
            end
            if ((acc && m_idx == 3) || (Flush_i && Ready_o && m_keep != 4'h0)) begin
                q.push_back({m_keep, m_acc});
                m_acc  = 32'h0;
                m_keep = 4'h0;
                m_idx  = 0;
            end else if (acc) begin
                m_idx++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    // Offer a byte until accepted (bounded), then drop valid/flush.
    task automatic send(input logic [7:0] b, input logic fl);
        int tries = 0;
        Valid_i = 1'b1;
        Data_i  = b;
        Flush_i = fl;
        do begin
            tick();
            tries++;
        end while (!last_acc && tries < 20);
        chk("send_accepted", 64'(last_acc), 64'd1);
        Valid_i = 1'b0;
        Flush_i = 1'b0;
    endtask

    initial begin
        RESET   = 1'b1;
        Valid_i = 1'b0;
        Data_i  = 8'h00;
        Flush_i = 1'b0;
        Ready_i = 1'b0;
        m_acc   = 32'h0;
        m_keep  = 4'h0;
        m_idx   = 0;
        tick();
        tick();
        RESET = 1'b0;
        chk("rst_valid", 64'(Valid_o), 64'd0);
        chk("rst_data",  64'(Data_o),  64'd0);
        chk("rst_keep",  64'(Keep_o),  64'd0);

        // Streaming at full rate
        Ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            Valid_i = 1'b1;
            Data_i  = 8'(i);
            #1;
            chk("stream_ready", 64'(Ready_o), 64'd1);
            tick();
            chk("stream_acc", 64'(last_acc), 64'd1);
            if (i == 4 || i == 8) begin
                chk("stream_vld_hi", 64'(Valid_o), 64'd1);
                chk("stream_word", 64'(Data_o), (i == 4) ? 64'h04030201 : 64'h08070605);
            end else begin
                chk("stream_vld_lo", 64'(Valid_o), 64'd0);
            end
        end
        Valid_i = 1'b0;
        tick();
        chk("stream_drop", 64'(Valid_o), 64'd0);

        // Reset mid-word discards partial data and clears the output register
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        chk("rst2_valid", 64'(Valid_o), 64'd0);
        chk("rst2_data",  64'(Data_o),  64'd0);
        chk("rst2_keep",  64'(Keep_o),  64'd0);
        for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 1'b0);
        chk("rst_word", 64'(Data_o), 64'hA3A2A1A0);
        chk("rst_keepf", 64'(Keep_o), 64'hF);
        tick();

        // Backpressure: first word held, last-lane byte stalls
        Ready_i = 1'b0;
        for (int i = 0; i < 7; i++) send(8'h10 + 8'(i), 1'b0);
        Valid_i = 1'b1;
        Data_i  = 8'h17;
        #1;
        chk("bp_ready_lo", 64'(Ready_o), 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bp_hold_vld", 64'(Valid_o), 64'd1);
            chk("bp_hold_data", 64'(Data_o), 64'h13121110);
        end
        Ready_i = 1'b1;
        tick();
        chk("bp_acc17", 64'(last_acc), 64'd1);
        Valid_i = 1'b0;
        chk("bp_vld2", 64'(Valid_o), 64'd1);
        chk("bp_word2", 64'(Data_o), 64'h17161514);
        tick();
        chk("bp_drain", 64'(Valid_o), 64'd0);

        // Flush of a partial word
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        chk("fl_vld", 64'(Valid_o), 64'd1);
        chk("fl_data", 64'(Data_o), 64'h00CCBBAA);
        chk("fl_keep", 64'(Keep_o), 64'h7);
        send(8'hDD, 1'b0);
        send(8'hEE, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h11, 1'b0);
        chk("fl_next_word", 64'(Data_o), 64'h11FFEEDD);
        tick();

        // Flush with nothing accumulated is a no-op
        Flush_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_idle_vld", 64'(Valid_o), 64'd0);
        end
        Flush_i = 1'b0;

        // Close on the same cycle as an output transfer: no bubble
        Ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h31 + 8'(i), 1'b0);
        for (int i = 0; i < 3; i++) send(8'h41 + 8'(i), 1'b0);
        chk("sim_pre_vld", 64'(Valid_o), 64'd1);
        Ready_i = 1'b1;
        send(8'h44, 1'b0);
        chk("sim_vld", 64'(Valid_o), 64'd1);
        chk("sim_word", 64'(Data_o), 64'h44434241);
        tick();
        chk("sim_drain", 64'(Valid_o), 64'd0);

        // Flush blocked by a full output register, then released
        Ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h51 + 8'(i), 1'b0);
        send(8'h61, 1'b0);
        Flush_i = 1'b1;
        #1;
        chk("flb_ready_lo", 64'(Ready_o), 64'd0);
        tick();
        chk("flb_hold", 64'(Data_o), 64'h54535251);
        Ready_i = 1'b1;
        tick();
        Flush_i = 1'b0;
        chk("flb_vld", 64'(Valid_o), 64'd1);
        chk("flb_data", 64'(Data_o), 64'h00000061);
        chk("flb_keep", 64'(Keep_o), 64'h1);
        tick();
        chk("flb_drain", 64'(Valid_o), 64'd0);

        chk("sb_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
